up_down_counter_sr: RTL and testbench

//   Free-running, parameterisable binary up/down counter with synchronous reset.

---
 rtl/up_down_counter_sr.sv | 41 ++++
 tb/tb_up_down_counter_sr.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/up_down_counter_sr.sv
`default_nettype none
// ============================================================================
//  Module      : up_down_counter_sr
//  Description : Free-running WIDTH-bit binary up/down counter with a
//                synchronous active-high reset. Wraps modulo 2^WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module up_down_counter_sr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,    // active-high despite the name
    input  logic             up_down,  // 1 = +1, 0 = -1
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    // Carry/borrow out of the top bit is dropped, giving natural wrap-around.
    always_comb begin
        w_count_next = r_count - c_ONE;
        if (up_down) begin
            w_count_next = r_count + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter_sr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_up_down_counter_sr
//  Description : Self-checking bench for up_down_counter_sr (WIDTH 4 and 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_up_down_counter_sr;

    logic       clk = 1'b0;
    logic       rst4, ud4;
    logic [3:0] count4;
    logic       rst8, ud8;
    logic [7:0] count8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    up_down_counter_sr #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst4),
        .up_down (ud4),
        .count   (count4)
    );

    up_down_counter_sr #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst8),
        .up_down (ud8),
        .count   (count8)
    );

    typedef struct {
        logic       rst;
        logic       ud;
        int         exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: count=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: modular arithmetic on plain integers.
    function automatic int model_next(input int cur, input bit rst, input bit up, input int modulus);
        if (rst)      return 0;
        else if (up)  return (cur + 1) % modulus;
        else          return (cur + modulus - 1) % modulus;
    endfunction

    task automatic edge4(input logic r, input logic u);
        rst4 = r;
        ud4  = u;
        @(posedge clk);
        #1;
    endtask

    task automatic edge8(input logic r, input logic u);
        rst8 = r;
        ud8  = u;
        @(posedge clk);
        #1;
    endtask

    int exp4;
    int exp8;

    initial begin
        rst4 = 1'b1; ud4 = 1'b1;
        rst8 = 1'b1; ud8 = 1'b1;

        vecs.push_back('{1'b1, 1'b1, 0,  "reset_edge1"});
        vecs.push_back('{1'b1, 1'b0, 0,  "reset_edge2"});
        vecs.push_back('{1'b0, 1'b0, 15, "down_from_rst_1"});
        vecs.push_back('{1'b0, 1'b0, 14, "down_2"});
        vecs.push_back('{1'b0, 1'b0, 13, "down_3"});
        vecs.push_back('{1'b0, 1'b1, 14, "up_1"});
        vecs.push_back('{1'b0, 1'b1, 15, "up_2"});
        vecs.push_back('{1'b0, 1'b1, 0,  "up_wrap"});
        vecs.push_back('{1'b0, 1'b1, 1,  "up_4"});
        vecs.push_back('{1'b0, 1'b1, 2,  "up_5"});
        vecs.push_back('{1'b0, 1'b0, 1,  "switch_down_1"});
        vecs.push_back('{1'b0, 1'b0, 0,  "switch_down_2"});
        vecs.push_back('{1'b0, 1'b0, 15, "down_wrap"});
        vecs.push_back('{1'b0, 1'b0, 14, "switch_down_4"});
        vecs.push_back('{1'b1, 1'b1, 0,  "reset_mid"});
        vecs.push_back('{1'b0, 1'b1, 1,  "resume_up_1"});
        vecs.push_back('{1'b0, 1'b1, 2,  "resume_up_2"});

        // Table-driven directed sequence (WIDTH=4)
        for (int i = 0; i < vecs.size(); i++) begin
            edge4(vecs[i].rst, vecs[i].ud);
            check(vecs[i].name, int'(count4), vecs[i].exp);
        end
        exp4 = 2;

        // Reset raised between edges must not act until the next posedge
        rst4 = 1'b1;
        #3;
        check("sync_rst_no_async", int'(count4), exp4);
        @(posedge clk);
        #1;
        exp4 = 0;
        check("sync_rst_at_edge", int'(count4), exp4);

        // Randomised run against the modular-arithmetic model
        for (int i = 0; i < 300; i++) begin
            logic r, u;
            r = ($urandom_range(0, 15) == 0);
            u = 1'($urandom);
            edge4(r, u);
            exp4 = model_next(exp4, r, u, 16);
            check($sformatf("rand4_%0d", i), int'(count4), exp4);
        end

        // WIDTH=8: full cycle of 256 up edges, then one down wrap
        edge8(1'b1, 1'b0);
        exp8 = 0;
        check("w8_reset", int'(count8), exp8);
        for (int i = 0; i < 256; i++) begin
            edge8(1'b0, 1'b1);
            exp8 = model_next(exp8, 1'b0, 1'b1, 256);
            check($sformatf("w8_up_%0d", i), int'(count8), exp8);
        end
        check("w8_full_cycle_zero", int'(count8), 0);
        edge8(1'b0, 1'b0);
        check("w8_down_wrap", int'(count8), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
